// File: rtl/dout_toggle_pulse_pkg.sv
// Shared constants and helpers for the toggle-to-pulse output path.
// State encoding is kept as plain 2-bit constants for legacy tool compatibility.
package dout_toggle_pulse_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dout_sync2.sv
// Two-flop synchronizer for a single-bit level, asynchronous active-high reset.
module dout_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/dout_toggle_pulse.sv
// Converts each level change of toggle_in into one fixed-width pulse on dout with an enforced gap.
// Define DOUT_TOGGLE_PULSE_SYNC_EN to pass toggle_in through a 2-flop synchronizer first.
module dout_toggle_pulse
  import dout_toggle_pulse_pkg::*;
#(
  parameter int PULSE_LEN = 1000,
  parameter int GAP_LEN   = 1000,
  parameter int PENDING_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic toggle_in,
  output logic dout,
  output logic busy,
  output logic overflow
);

  localparam int CNT_W = clog2(max2(PULSE_LEN, GAP_LEN) + 1);
  localparam logic [CNT_W-1:0]     PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]     GAP_LOAD   = CNT_W'(GAP_LEN - 1);
  localparam logic [PENDING_W-1:0] PEND_MAX   = '1;

  logic tog_src;

`ifdef DOUT_TOGGLE_PULSE_SYNC_EN
  // Priming waits until the synchronizer holds a real sample of toggle_in.
  localparam int PRIME_STAGES = 3;
  dout_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (toggle_in),
    .q   (tog_src)
  );
`else
  localparam int PRIME_STAGES = 1;
  assign tog_src = toggle_in;
`endif

  logic                    tog_q, tog_d;
  logic [PRIME_STAGES-1:0] prime_q, prime_d;
  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PENDING_W-1:0]    pend_q, pend_d;
  logic                    dout_q, dout_d;
  logic                    busy_q, busy_d;
  logic                    ovf_q, ovf_d;

  logic primed;
  logic change;
  logic can_start;
  logic start;

  assign primed = prime_q[PRIME_STAGES-1];

  always_comb begin
    tog_d     = tog_src;
    prime_d   = PRIME_STAGES'({prime_q, 1'b1});
    change    = primed & (tog_src ^ tog_q);
    // The last gap cycle can hand straight over to the next pulse, keeping the gap exactly GAP_LEN.
    can_start = (state_q == IDLE) | ((state_q == GAP) & (cnt_q == '0));
    start     = can_start & (change | (pend_q != '0));

    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PULSE;
          dout_d  = 1'b1;
          cnt_d   = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = GAP;
          dout_d  = 1'b0;
          cnt_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (start) begin
          state_d = PULSE;
          dout_d  = 1'b1;
          cnt_d   = PULSE_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    if (change & ~start) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (start & ~change) begin
      pend_d = pend_q - 1'b1;
    end

    busy_d = (state_d != IDLE) | (pend_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q   <= 1'b0;
      prime_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      tog_q   <= tog_d;
      prime_q <= prime_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout     = dout_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_dout_toggle_pulse.sv
// Directed bench for dout_toggle_pulse: per-edge expected outputs are queued with the stimulus
// and checked half a cycle after each edge.
module tb_dout_toggle_pulse;

  localparam int PL = 4;
  localparam int GL = 3;
  localparam int PW = 2;
`ifdef DOUT_TOGGLE_PULSE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic toggle_in = 1'b0;
  logic dout;
  logic busy;
  logic overflow;

  int n_checks = 0;
  int n_fails  = 0;

  logic [2:0] exp_q[$];

  dout_toggle_pulse #(
    .PULSE_LEN (PL),
    .GAP_LEN   (GL),
    .PENDING_W (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .toggle_in (toggle_in),
    .dout      (dout),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic act, input logic exp);
    n_checks++;
    assert (act === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endtask

  task automatic do_reset(input logic lvl);
    rst = 1'b1;
    toggle_in = lvl;
    repeat (2) @(negedge clk);
    check("reset dout", dout, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset overflow", overflow, 1'b0);
    rst = 1'b0;
  endtask

  // Edge e is the e-th posedge after reset release; flips[e] changes toggle_in just before edge e.
  task automatic run(input string name, input int n, input logic [63:0] flips,
                     input logic [63:0] starts, input int ovf_edge);
    int first_s;
    int last_s;
    logic [2:0] exp;
    logic [2:0] got;
    first_s = -1;
    last_s  = -1;
    for (int s = 1; s < 64; s++) begin
      if (starts[s]) begin
        if (first_s < 0) first_s = s;
        last_s = s;
      end
    end
    for (int e = 1; e <= n; e++) begin
      logic d;
      logic b;
      logic o;
      if (flips[e]) toggle_in = ~toggle_in;
      d = 1'b0;
      for (int s = 1; s < 64; s++) begin
        if (starts[s] && (e >= s + LAT) && (e <= s + LAT + PL - 1)) d = 1'b1;
      end
      b = (first_s > 0) && (e >= first_s + LAT) && (e <= last_s + LAT + PL + GL - 1);
      o = (ovf_edge > 0) && (e >= ovf_edge + LAT);
      exp_q.push_back({d, b, o});
      @(posedge clk);
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {dout, busy, overflow};
      $display("%s edge %0d: toggle_in=%b dout=%b busy=%b overflow=%b (exp %b%b%b)",
               name, e, toggle_in, got[2], got[1], got[0], exp[2], exp[1], exp[0]);
      check({name, " dout"}, got[2], exp[2]);
      check({name, " busy"}, got[1], exp[1]);
      check({name, " overflow"}, got[0], exp[0]);
    end
  endtask

  initial begin
    logic [63:0] f;
    logic [63:0] s;

    // Level present at release must never pulse.
    do_reset(1'b1);
    run("t1_prime", 20, 64'd0, 64'd0, 0);

    do_reset(1'b0);
    f = 64'd1 << 10;
    run("t2_single", 20, f, f, 0);

    do_reset(1'b0);
    f = (64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12);
    s = (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 24);
    run("t3_three", 34, f, s, 0);

    do_reset(1'b0);
    f = (64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12) | (64'd1 << 13) | (64'd1 << 14);
    s = (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 24) | (64'd1 << 31);
    run("t4_overflow", 42, f, s, 14);

    // Reset in the middle of a pulse with a second event queued.
    do_reset(1'b0);
    f = (64'd1 << 10) | (64'd1 << 11);
    s = 64'd1 << 10;
    run("t5_pre", 13, f, s, 0);
    rst = 1'b1;
    #1;
    check("t5 async dout", dout, 1'b0);
    check("t5 async busy", busy, 1'b0);
    check("t5 async overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run("t5_post", 20, 64'd0, 64'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
